inst_queue: RTL
===============

// Module: inst_queue
// PURPOSE
//  Decoupling FIFO between the instruction fetcher and decode/dispatch. Buffers (inst, pc) pairs
//  pushed by the fetcher and presents the oldest pair to the decoder with a valid/ready handshake.
//  Raises a conservative full flag that covers the fetcher's one-cycle registered push latency.
//  Discards all buffered entries on a ROB redirect.
// PARAMETERS
//  DEPTH   16  number of entries; must be a power of two and >= 4
//  ADDR_W   4  pointer width; must equal log2(DEPTH)
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  rdy            in   1   global enable; low = freeze all state
//  IF_inst_valid  in   1   fetcher pushes {IF_inst, IF_pc} this cycle
//  IF_inst        in   32  instruction word
//  IF_pc          in   32  instruction address
//  IF_full        out  1   fetcher must not start a new push next cycle
//  ID_ready       in   1   decoder accepts the head entry this cycle
//  ID_inst_valid  out  1   head entry valid
//  ID_inst        out  32  head instruction
//  ID_pc          out  32  head pc
//  ROB_is_jump    in   1   redirect: flush all entries
// BEHAVIOUR
//  - Storage: inst_mem[DEPTH], pc_mem[DEPTH], head, tail (ADDR_W bits, wrap naturally),
//    count (ADDR_W+1 bits, 0..DEPTH).
//  - Reset: head = tail = count = 0. Outputs: ID_inst_valid = 0, IF_full = 0, ID_inst/ID_pc = head
//    contents (don't-care). Memories are not cleared.
//  - Reset mid-operation: the same, and it overrides everything else.
//  - push = rdy & IF_inst_valid & ~ROB_is_jump & (count != DEPTH).
//  - pop = rdy & ID_inst_valid & ID_ready & ~ROB_is_jump.
//  - Push writes at tail, then tail += 1. Pop advances head += 1.
//  - count += push - pop. A simultaneous push and pop leaves count unchanged.
//  - Push into an empty queue: the entry is visible on ID_* the next cycle (1-cycle latency).
//  - ID_inst_valid = rdy & (count != 0). ID_inst = inst_mem[head], ID_pc = pc_mem[head]
//    (combinational read).
//  - IF_full = (count >= DEPTH-1), combinational from count.
//    * Rationale: a push already in flight plus one decided push can still land.
//    * Consequence: at most 2 pushes follow the cycle in which IF_full = 0.
//  - Overflow: a push with count == DEPTH is dropped. It cannot occur with a correct fetcher.
//    The bench asserts it never happens.
//  - Flush (rdy & ROB_is_jump): head = tail = count = 0 next cycle. A same-cycle push or pop is
//    ignored, including the stale wrong-path push the fetcher presents in that cycle.
//  - Flush with reset: reset wins.
//  - rdy low: no state change; push, pop and flush are all ignored; ID_inst_valid = 0.
//  - No FSM; occupancy is tracked by count. Full at count == DEPTH, empty at count == 0;
//    pointers wrap from DEPTH-1 to 0.
// CONFIGURATION
//  INST_QUEUE_BYPASS_EN
//  - Defined: when count == 0, rdy, IF_inst_valid and ~ROB_is_jump, drive ID_inst_valid = 1 and
//    ID_inst/ID_pc = IF_inst/IF_pc combinationally (0-cycle latency).
//    * If ID_ready is also high, the entry is consumed directly: no write, count stays 0.
//    * If ID_ready is low, the entry is written normally.
//  - Not defined: no bypass; minimum push-to-ID latency is 1 cycle.
// TESTING
//  1. Reset, push pc 0x0/0x4/0x8 with ID_ready = 0, then ID_ready = 1 -> ID_pc 0x0, 0x4, 0x8
//     on consecutive cycles, then ID_inst_valid = 0.
//  2. ID_ready = 0, push every cycle -> IF_full = 1 on the cycle count reaches 15. A
//     fetcher-model bench never exceeds count 16; no overflow drop.
//  3. Fill to 10, assert ROB_is_jump with a push present -> next cycle count = 0,
//     ID_inst_valid = 0, IF_full = 0; the next push of pc 0x100 appears at the head.
//  4. Count = 8, simultaneous push and pop for 20 cycles -> count stays 8; pointers wrap;
//     pc order preserved.
//  5. rdy = 0 for 5 cycles with IF_inst_valid = 1 and ID_ready = 1 -> count unchanged and
//     ID_inst_valid = 0; after rdy returns, the queue resumes in order.
//  6. BYPASS_EN defined, empty, push pc 0x40 with ID_ready = 1 -> ID_pc = 0x40 the same cycle;
//     count stays 0. Macro undefined -> ID_pc = 0x40 one cycle later.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: decoupling FIFO between the instruction fetcher and decode.
// Buffers (inst, pc) pairs and presents the oldest pair on ID_*.
// IF_full is raised one entry early so that a push already in flight and a
// push decided in the IF_full=0 cycle can both still land.
// A ROB redirect (ROB_is_jump) discards everything buffered.
// Optional feature macro: INST_QUEUE_BYPASS_EN. When it is defined, an empty
// queue forwards the fetcher's pair straight to ID_* in the same cycle.
module inst_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        IF_inst_valid,
  input  logic [31:0] IF_inst,
  input  logic [31:0] IF_pc,
  output logic        IF_full,
  input  logic        ID_ready,
  output logic        ID_inst_valid,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc,
  input  logic        ROB_is_jump
);

  localparam logic [ADDR_W:0] LP_DEPTH    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_DEPTH_M1 = (ADDR_W+1)'(DEPTH - 1);

  logic [31:0]     r_inst_mem [DEPTH];
  logic [31:0]     r_pc_mem   [DEPTH];
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_count;

  logic w_not_empty;
  logic w_flush;
  logic w_push;
  logic w_pop;
  logic w_bypass_take;

  assign w_not_empty = (r_count != '0);
  assign w_flush     = rdy & ROB_is_jump;
  // Pop only ever consumes a stored entry; a bypassed entry never occupies a slot.
  assign w_pop       = rdy & w_not_empty & ID_ready & ~ROB_is_jump;

`ifdef INST_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass      = rdy & IF_inst_valid & ~ROB_is_jump & ~w_not_empty;
  assign w_bypass_take = w_bypass & ID_ready;
  assign ID_inst_valid = (rdy & w_not_empty) | w_bypass;
  assign ID_inst       = w_bypass ? IF_inst : r_inst_mem[r_head];
  assign ID_pc         = w_bypass ? IF_pc   : r_pc_mem[r_head];
`else
  assign w_bypass_take = 1'b0;
  assign ID_inst_valid = rdy & w_not_empty;
  assign ID_inst       = r_inst_mem[r_head];
  assign ID_pc         = r_pc_mem[r_head];
`endif

  // A push at count == DEPTH is dropped, and a bypass-consumed entry is not stored.
  assign w_push  = rdy & IF_inst_valid & ~ROB_is_jump & (r_count != LP_DEPTH) & ~w_bypass_take;
  assign IF_full = (r_count >= LP_DEPTH_M1);

  // Storage write at the tail; contents are never cleared.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_inst_mem[r_tail] <= IF_inst;
      r_pc_mem[r_tail]   <= IF_pc;
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + ADDR_W'(1);
      if (w_pop)  r_head <= r_head + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
